// File: rtl/sig_control_pkg.sv
// Shared definitions for the timed two-road signal controller:
// lamp encodings, phase codes and the phase-to-lamp decode.
package sig_control_pkg;

  localparam logic [2:0] LAMP_GRN = 3'b001;
  localparam logic [2:0] LAMP_YEL = 3'b010;
  localparam logic [2:0] LAMP_RED = 3'b100;

  // Phase codes are visible on the phase output, so the values are fixed.
  typedef enum logic [2:0] {
    HG  = 3'd0,
    HY  = 3'd1,
    RR1 = 3'd2,
    CG  = 3'd3,
    CY  = 3'd4,
    RR2 = 3'd5
  } phase_e;

  typedef struct packed {
    logic [2:0] hwy;
    logic [2:0] crd;
  } lamps_t;

  // Lamp pattern shown for a phase; anything unrecognised shows red on both
  // roads so a corrupted code can never light two non-red approaches.
  function automatic lamps_t phaseLamps(input phase_e p);
    lamps_t l;
    case (p)
      HG:      begin l.hwy = LAMP_GRN; l.crd = LAMP_RED; end
      HY:      begin l.hwy = LAMP_YEL; l.crd = LAMP_RED; end
      RR1:     begin l.hwy = LAMP_RED; l.crd = LAMP_RED; end
      CG:      begin l.hwy = LAMP_RED; l.crd = LAMP_GRN; end
      CY:      begin l.hwy = LAMP_RED; l.crd = LAMP_YEL; end
      RR2:     begin l.hwy = LAMP_RED; l.crd = LAMP_RED; end
      default: begin l.hwy = LAMP_RED; l.crd = LAMP_RED; end
    endcase
    return l;
  endfunction

endpackage

// File: rtl/sig_phase_timer.sv
// Phase timer: counts cycles spent in the current phase. A restart request
// loads zero on the next edge; otherwise the count climbs and sticks at its
// maximum so a very long highway green never wraps back below a threshold.
module sig_phase_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             restart_i,
  output logic [CNT_W-1:0] count_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Restart wins over counting; a saturated count holds its value.
  always_comb begin
    count_d = count_q;
    if (restart_i) begin
      count_d = '0;
    end else if (count_q != CNT_MAX) begin
      count_d = count_q + 1'b1;
    end
  end

  // Count register, cleared asynchronously with the rest of the controller.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/sig_control_timed.sv
// Timed highway/country-road signal controller.
// Optional build macro SIG_PREEMPT_EN adds a 'preempt' input that gives
// emergency priority to the highway without shortening yellow or all-red.
module sig_control_timed
  import sig_control_pkg::*;
#(
  parameter int CNT_W       = 8,
  parameter int YEL_CYC     = 3,
  parameter int AR_CYC      = 2,
  parameter int HWY_MIN_GRN = 10,
  parameter int CRD_MAX_GRN = 20
) (
  input  logic       clock,
  input  logic       clear,
  input  logic       x,
`ifdef SIG_PREEMPT_EN
  input  logic       preempt,
`endif
  output logic [2:0] hwy,
  output logic [2:0] crd,
  output logic [2:0] phase,
  output logic       timeout
);

  // Timer values at which each timed phase ends ("k cycles" ends at k-1).
  localparam logic [CNT_W-1:0] YEL_LAST = CNT_W'(YEL_CYC - 1);
  localparam logic [CNT_W-1:0] AR_LAST  = CNT_W'(AR_CYC - 1);
  localparam logic [CNT_W-1:0] HG_LAST  = CNT_W'(HWY_MIN_GRN - 1);
  localparam logic [CNT_W-1:0] CG_LAST  = CNT_W'(CRD_MAX_GRN - 1);

  phase_e           phase_q;
  phase_e           phase_d;
  logic             req_q;
  logic             req_d;
  logic             timeout_q;
  logic             timeout_d;
  logic [2:0]       hwy_q;
  logic [2:0]       crd_q;
  logic [CNT_W-1:0] timer;
  logic             phaseChange;
  logic             preemptOn;
  lamps_t           lampsNext;

`ifdef SIG_PREEMPT_EN
  assign preemptOn = preempt;
`else
  assign preemptOn = 1'b0;
`endif

  assign phaseChange = (phase_d != phase_q);

  sig_phase_timer #(
    .CNT_W(CNT_W)
  ) u_timer (
    .clock     (clock),
    .clear     (clear),
    .restart_i (phaseChange),
    .count_o   (timer)
  );

  // Next phase and the max-green timeout flag; preemption forces the
  // country road off and keeps the highway green, but the timed yellow and
  // all-red intervals always run to completion.
  always_comb begin
    phase_d   = phase_q;
    timeout_d = 1'b0;
    case (phase_q)
      HG: begin
        if (!preemptOn && (req_q || x) && (timer >= HG_LAST)) begin
          phase_d = HY;
        end
      end
      HY: begin
        if (timer == YEL_LAST) begin
          phase_d = RR1;
        end
      end
      RR1: begin
        if (timer == AR_LAST) begin
          phase_d = preemptOn ? RR2 : CG;
        end
      end
      CG: begin
        if (preemptOn) begin
          phase_d = CY;
        end else if (timer == CG_LAST) begin
          phase_d   = CY;
          timeout_d = 1'b1;
        end else if (!x) begin
          phase_d = CY;
        end
      end
      CY: begin
        if (timer == YEL_LAST) begin
          phase_d = RR2;
        end
      end
      RR2: begin
        if (timer == AR_LAST) begin
          phase_d = HG;
        end
      end
      default: begin
        phase_d = HG;
      end
    endcase
  end

  // Request latch: remembers a car seen during highway green so that a
  // one-cycle sensor pulse still gets served; released once country green
  // begins.
  always_comb begin
    req_d = req_q;
    if ((phase_d == CG) && (phase_q != CG)) begin
      req_d = 1'b0;
    end else if ((phase_q == HG) && x) begin
      req_d = 1'b1;
    end
  end

  assign lampsNext = phaseLamps(phase_d);

  // Phase FSM state with registered lamps decoded from the next phase, so
  // lamps and phase code change on the same edge.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      phase_q   <= HG;
      req_q     <= 1'b0;
      timeout_q <= 1'b0;
      hwy_q     <= LAMP_GRN;
      crd_q     <= LAMP_RED;
    end else begin
      phase_q   <= phase_d;
      req_q     <= req_d;
      timeout_q <= timeout_d;
      hwy_q     <= lampsNext.hwy;
      crd_q     <= lampsNext.crd;
    end
  end

  assign phase   = phase_q;
  assign hwy     = hwy_q;
  assign crd     = crd_q;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_sig_control_timed.sv
// Testbench for sig_control_timed: a cycle model predicts every output
// vector into a scoreboard queue, and phase entry cycles are also checked
// against fixed timing constants for each scenario.
// Build with SIG_PREEMPT_EN defined to exercise the preemption scenarios.
module tb_sig_control_timed;

  localparam int YEL_CYC     = 3;
  localparam int AR_CYC      = 2;
  localparam int HWY_MIN_GRN = 10;
  localparam int CRD_MAX_GRN = 20;

  localparam int P_HG  = 0;
  localparam int P_HY  = 1;
  localparam int P_RR1 = 2;
  localparam int P_CG  = 3;
  localparam int P_CY  = 4;
  localparam int P_RR2 = 5;

  typedef logic [9:0] obs_t;

  logic       clock = 1'b0;
  logic       clear;
  logic       x;
`ifdef SIG_PREEMPT_EN
  logic       preempt;
`endif
  logic [2:0] hwy;
  logic [2:0] crd;
  logic [2:0] phase;
  logic       timeout;

  obs_t expQ[$];
  int   transQ[$];
  int   testsRun = 0;
  int   testsFailed = 0;

  int   mPhase;
  int   mAge;
  logic mReq;
  logic mTimeout;

  int   cycleNum;
  int   lastPhase;
  int   timeoutSeen;

  sig_control_timed #(
    .CNT_W       (8),
    .YEL_CYC     (YEL_CYC),
    .AR_CYC      (AR_CYC),
    .HWY_MIN_GRN (HWY_MIN_GRN),
    .CRD_MAX_GRN (CRD_MAX_GRN)
  ) dut (
    .clock   (clock),
    .clear   (clear),
    .x       (x),
`ifdef SIG_PREEMPT_EN
    .preempt (preempt),
`endif
    .hwy     (hwy),
    .crd     (crd),
    .phase   (phase),
    .timeout (timeout)
  );

  // Free-running clock, period 10.
  always #5 clock = ~clock;

  // Safety net in case the bench itself stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed no completion, expected summary before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  function automatic logic [5:0] modelLamps(input int p);
    case (p)
      P_HG:    return {3'b001, 3'b100};
      P_HY:    return {3'b010, 3'b100};
      P_RR1:   return {3'b100, 3'b100};
      P_CG:    return {3'b100, 3'b001};
      P_CY:    return {3'b100, 3'b010};
      default: return {3'b100, 3'b100};
    endcase
  endfunction

  function automatic obs_t modelVec();
    logic [2:0] ph;
    ph = mPhase[2:0];
    return {ph, modelLamps(mPhase), mTimeout};
  endfunction

  task automatic modelReset();
    mPhase   = P_HG;
    mAge     = 0;
    mReq     = 1'b0;
    mTimeout = 1'b0;
  endtask

  // One clock edge of the intended behaviour; mAge is the number of whole
  // cycles already spent in the current phase.
  task automatic modelStep(input logic xv, input logic pv);
    int   np;
    logic nt;
    np = mPhase;
    nt = 1'b0;
    case (mPhase)
      P_HG:  if (!pv && (mReq || xv) && mAge >= HWY_MIN_GRN - 1) np = P_HY;
      P_HY:  if (mAge == YEL_CYC - 1) np = P_RR1;
      P_RR1: if (mAge == AR_CYC - 1) np = pv ? P_RR2 : P_CG;
      P_CG: begin
        if (pv) np = P_CY;
        else if (mAge == CRD_MAX_GRN - 1) begin np = P_CY; nt = 1'b1; end
        else if (!xv) np = P_CY;
      end
      P_CY:  if (mAge == YEL_CYC - 1) np = P_RR2;
      P_RR2: if (mAge == AR_CYC - 1) np = P_HG;
      default: np = P_HG;
    endcase
    if (np == P_CG && mPhase != P_CG) mReq = 1'b0;
    else if (mPhase == P_HG && xv) mReq = 1'b1;
    mAge     = (np == mPhase) ? mAge + 1 : 0;
    mPhase   = np;
    mTimeout = nt;
  endtask

  // Drive one cycle of inputs, queue the predicted outputs, then compare
  // just after the edge and log phase entries by cycle number.
  task automatic applyStimulus(input logic xv, input logic pv, input logic cv,
                               input string name);
    obs_t expVal;
    obs_t obsVal;
    @(negedge clock);
    clear = cv;
    x     = xv;
`ifdef SIG_PREEMPT_EN
    preempt = pv;
`endif
    if (cv) modelReset();
    else modelStep(xv, pv);
    expQ.push_back(modelVec());
    @(posedge clock);
    #1;
    obsVal = {phase, hwy, crd, timeout};
    expVal = expQ.pop_front();
    checkOutput($sformatf("%s c%0d", name, cycleNum), 32'(obsVal), 32'(expVal));
    if (!cv) begin
      if (int'(phase) != lastPhase) begin
        transQ.push_back(int'(phase) * 1000 + cycleNum + 1);
        lastPhase = int'(phase);
      end
      if (timeout) timeoutSeen++;
      cycleNum++;
    end
  endtask

  task automatic startTest();
    cycleNum    = 0;
    lastPhase   = P_HG;
    timeoutSeen = 0;
    transQ.delete();
  endtask

  task automatic resetDut(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b1, "reset");
    startTest();
  endtask

  // Compare the next logged phase entry with an expected phase and cycle.
  task automatic expectTrans(input string name, input int ph, input int cyc);
    int got;
    if (transQ.size() == 0) got = -1;
    else got = transQ.pop_front();
    checkOutput($sformatf("%s enter %0d@%0d", name, ph, cyc), 32'(got), 32'(ph * 1000 + cyc));
  endtask

  task automatic expectNoMoreTrans(input string name);
    checkOutput($sformatf("%s extra", name), 32'(transQ.size()), 32'd0);
  endtask

  // Scenario sequence: reset, idle, request timing, max-green, pulse
  // latch, timer saturation, asynchronous clear, and optional preemption.
  initial begin
    clear = 1'b1;
    x     = 1'b0;
`ifdef SIG_PREEMPT_EN
    preempt = 1'b0;
`endif
    modelReset();
    startTest();

    resetDut(50);
    for (int i = 0; i < 20; i++) applyStimulus(1'b0, 1'b0, 1'b0, "idle");
    expectNoMoreTrans("idle");

    resetDut(2);
    for (int i = 0; i < 40; i++) applyStimulus(i < 30, 1'b0, 1'b0, "hold30");
    expectTrans("hold30", P_HY, 10);
    expectTrans("hold30", P_RR1, 13);
    expectTrans("hold30", P_CG, 15);
    expectTrans("hold30", P_CY, 31);
    expectTrans("hold30", P_RR2, 34);
    expectTrans("hold30", P_HG, 36);
    expectNoMoreTrans("hold30");

    resetDut(2);
    for (int i = 0; i < 100; i++) applyStimulus(1'b1, 1'b0, 1'b0, "hold100");
    expectTrans("hold100", P_HY, 10);
    expectTrans("hold100", P_RR1, 13);
    expectTrans("hold100", P_CG, 15);
    expectTrans("hold100", P_CY, 35);
    expectTrans("hold100", P_RR2, 38);
    expectTrans("hold100", P_HG, 40);
    expectTrans("hold100", P_HY, 50);
    expectTrans("hold100", P_RR1, 53);
    expectTrans("hold100", P_CG, 55);
    expectTrans("hold100", P_CY, 75);
    expectTrans("hold100", P_RR2, 78);
    expectTrans("hold100", P_HG, 80);
    expectTrans("hold100", P_HY, 90);
    expectTrans("hold100", P_RR1, 93);
    expectTrans("hold100", P_CG, 95);
    expectNoMoreTrans("hold100");
    checkOutput("hold100 timeouts", 32'(timeoutSeen), 32'd2);

    resetDut(2);
    for (int i = 0; i < 25; i++) applyStimulus(i == 3, 1'b0, 1'b0, "pulse3");
    expectTrans("pulse3", P_HY, 10);
    expectTrans("pulse3", P_RR1, 13);
    expectTrans("pulse3", P_CG, 15);
    expectTrans("pulse3", P_CY, 16);
    expectTrans("pulse3", P_RR2, 19);
    expectTrans("pulse3", P_HG, 21);
    expectNoMoreTrans("pulse3");

    resetDut(2);
    for (int i = 0; i < 262; i++) applyStimulus(i == 260, 1'b0, 1'b0, "satur");
    expectTrans("satur", P_HY, 261);
    expectNoMoreTrans("satur");

    resetDut(2);
    for (int i = 0; i < 60 && mPhase != P_CY; i++) applyStimulus(1'b1, 1'b0, 1'b0, "toCY");
    checkOutput("reach CY", 32'(phase), 32'(P_CY));
    #2;
    clear = 1'b1;
    #1;
    checkOutput("async clear", 32'({phase, hwy, crd, timeout}),
                32'({3'd0, 3'b001, 3'b100, 1'b0}));
    modelReset();
    applyStimulus(1'b0, 1'b0, 1'b1, "clrHold");
    startTest();
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0, 1'b0, "afterClr");
    expectNoMoreTrans("afterClr");

`ifdef SIG_PREEMPT_EN
    resetDut(2);
    for (int i = 0; i < 25; i++) applyStimulus(1'b1, i == 17, 1'b0, "preCG");
    expectTrans("preCG", P_HY, 10);
    expectTrans("preCG", P_RR1, 13);
    expectTrans("preCG", P_CG, 15);
    expectTrans("preCG", P_CY, 18);
    expectTrans("preCG", P_RR2, 21);
    expectTrans("preCG", P_HG, 23);
    expectNoMoreTrans("preCG");
    checkOutput("preCG timeouts", 32'(timeoutSeen), 32'd0);

    resetDut(2);
    for (int i = 0; i < 28; i++) applyStimulus(1'b1, (i == 13) || (i == 14), 1'b0, "preRR1");
    expectTrans("preRR1", P_HY, 10);
    expectTrans("preRR1", P_RR1, 13);
    expectTrans("preRR1", P_RR2, 15);
    expectTrans("preRR1", P_HG, 17);
    expectTrans("preRR1", P_HY, 27);
    expectNoMoreTrans("preRR1");

    resetDut(2);
    for (int i = 0; i < 33; i++) applyStimulus(1'b1, i < 30, 1'b0, "preHG");
    expectTrans("preHG", P_HY, 31);
    expectNoMoreTrans("preHG");
`endif

    checkOutput("scoreboard drained", 32'(expQ.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
